memory_arbiter: RTL
===================

Name: memory_arbiter

Overview:
Two-port arbiter/sequencer in front of the single 8x8 `memory_module`. Two requester clients issue read/write transactions with a req/ack handshake. The block grants one client at a time in round-robin order. It drives the memory's chip_select/rE/wE/address/data strobes for exactly one access cycle. It returns read data to the granted client with a one-cycle ack pulse.

Parameters:
DATA_W, 8, data width (matches memory word).
ADDR_W, 3, address width (8 locations).
RD_LATENCY, 1, cycles from the read access cycle until `mem_dataOut` is valid; legal 1..3.

Ports:
clock  in  1  system clock; all state updates on rising edge.
reset  in  1  asynchronous, active-low reset.
req0, req1  in  1  transaction request from client 0 / 1.
we0, we1  in  1  1 = write, 0 = read; sampled with req.
addr0, addr1  in  ADDR_W  target address per client.
wdata0, wdata1  in  DATA_W  write data per client.
gnt0, gnt1  out  1  client owns the memory (transaction in flight).
ack0, ack1  out  1  one-cycle completion pulse.
rdata  out  DATA_W  read data; valid while the ack is high for a read.
mem_data  out  DATA_W  write data to the memory.
mem_address  out  ADDR_W  address to the memory.
mem_cs, mem_rE, mem_wE  out  1  memory chip select / read enable / write enable.
mem_dataOut  in  DATA_W  read data from the memory.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, last_gnt=1, so client 0 wins the first tie.
  - All outputs are 0, including mem strobes, which drop immediately.
  - The latched op/addr/data/rdata are cleared.
- FSM states: IDLE, ACCESS, RDWAIT, DONE.
- IDLE:
  - req0 and req1 are sampled only here.
  - One request: grant it.
  - Both requests: grant the client != last_gnt.
  - On grant: latch we/addr/wdata of the winner, set gnt_x, update last_gnt, go to ACCESS.
  - Without a grant, all strobes are 0.
- ACCESS (exactly 1 cycle):
  - mem_cs=1, mem_address=latched addr.
  - Write: mem_wE=1, mem_rE=0, mem_data=latched wdata, next state DONE.
  - Read: mem_rE=1, mem_wE=0, mem_data=0, next state RDWAIT.
- RDWAIT:
  - Count RD_LATENCY cycles with mem_cs=1, mem_rE=1.
  - On the last count, capture mem_dataOut into rdata, then go to DONE.
- DONE:
  - ack_x=1 for one cycle, strobes 0, gnt_x still 1. Next state IDLE, where gnt_x clears.
- Latency (req high in IDLE at cycle 0):
  - Write: ack at cycle 2.
  - Read: ack at cycle 2+RD_LATENCY.
  - Back-to-back: next grant decision 1 cycle after ack.
- Handshake:
  - Clients hold req/we/addr/wdata until their ack.
  - Changes after the grant are ignored (the latched copy is used).
  - A client must drop req in the cycle after ack. If req is still high, it is treated as a new request, and round-robin hands a waiting other client the turn first.
- rdata holds its last value until the next read capture. Writes do not change rdata.
- gnt0 & gnt1 is never 1. mem_rE & mem_wE is never 1.
- Reset mid-transaction: the transaction is abandoned, no ack is issued, and the memory may or may not have been written.

Optional Feature:
- Macro MEMORY_ARBITER_STATS_EN.
- Defined:
  - Adds outputs grant_cnt0 and grant_cnt1, each 8 bits.
  - Each counter increments by 1 on every ack of its client and saturates at 255.
  - Both clear on reset.
- Undefined: the ports and logic are absent.
- Arbitration timing is identical either way.

Decomposition:
- Package memory_arbiter_pkg:
  - state enum (IDLE/ACCESS/RDWAIT/DONE).
  - DATA_W/ADDR_W default constants.
  - Stats counter width/max constant.
- Sub-module rr_arbiter_2:
  - Combinational 2-way round-robin pick from req0, req1 and last_gnt.
  - Outputs grant_valid and winner.
- Everything else lives in memory_arbiter.

Test Plan:
- Write then read back (RD_LATENCY=1):
  - req0,we0=1,addr0=3,wdata0=8'hA5 → mem_wE=1, mem_address=3 at cycle 1; ack0 at cycle 2.
  - Then req1 read addr1=3 → ack1 at cycle 3 with rdata=8'hA5.
- Simultaneous requests after reset:
  - req0=req1=1 held → grants alternate 0,1,0,1.
  - gnt0 and gnt1 are never both high; mem_rE/mem_wE are never both high.
- Mid-transaction change: change addr0 and wdata0 during ACCESS → memory sees the originally latched values only.
- Reset mid-read:
  - Assert reset=0 during RDWAIT → all outputs 0 asynchronously, no ack.
  - After release, client 0 wins a tie.
- RD_LATENCY=3 read → mem_rE high for 4 cycles; ack at cycle 5; rdata equals mem_dataOut from the final wait cycle.
- With MEMORY_ARBITER_STATS_EN: 300 client-0 writes → grant_cnt0=255, grant_cnt1=0.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for the two-client memory arbiter.
package memory_arbiter_pkg;

    localparam int unsigned MEM_DATA_W = 8;
    localparam int unsigned MEM_ADDR_W = 3;

    localparam int unsigned         STAT_W   = 8;
    localparam logic [STAT_W-1:0]   STAT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RDWAIT = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Saturating increment for the per-client grant counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == STAT_MAX) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Client handshake and memory strobe bundle between the arbiter (slave) and its clients/memory (master).
interface memory_arbiter_if
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = MEM_DATA_W,
    parameter int unsigned ADDR_W = MEM_ADDR_W
);

    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;

    logic              gnt0;
    logic              gnt1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata;

    logic [DATA_W-1:0] mem_data;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_cs;
    logic              mem_rE;
    logic              mem_wE;
    logic [DATA_W-1:0] mem_dataOut;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dataOut,
        output gnt0, gnt1, ack0, ack1, rdata,
               mem_data, mem_address, mem_cs, mem_rE, mem_wE
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dataOut,
        input  gnt0, gnt1, ack0, ack1, rdata,
               mem_data, mem_address, mem_cs, mem_rE, mem_wE
    );

endinterface

// File: rtl/rr_arbiter_2.sv
// Combinational two-way round-robin pick: on a tie the client that did not win last time goes next.
module rr_arbiter_2 (
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic grant_valid,
    output logic winner
);

    always_comb begin
        grant_valid = req0 | req1;
        winner      = 1'b0;
        if (req0 && req1) begin
            winner = ~last_gnt;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin arbiter/sequencer sharing one 8x8 memory between two req/ack clients.
// Optional grant counters are compiled in with MEMORY_ARBITER_STATS_EN.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W     = MEM_DATA_W,
    parameter int unsigned ADDR_W     = MEM_ADDR_W,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                clock,
    input  logic                reset,
`ifdef MEMORY_ARBITER_STATS_EN
    output logic [STAT_W-1:0]   grant_cnt0,
    output logic [STAT_W-1:0]   grant_cnt1,
`endif
    memory_arbiter_if.slave     bus
);

    localparam int unsigned       WAIT_W    = 2;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LATENCY - 1);

    state_e            state, state_d;
    logic              last_gnt, last_gnt_d;
    logic              lat_client, lat_client_d;
    logic              lat_we, lat_we_d;
    logic [ADDR_W-1:0] lat_addr, lat_addr_d;
    logic [DATA_W-1:0] lat_data, lat_data_d;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_d;
    logic              rd_last;

    logic              arb_valid;
    logic              arb_winner;

    logic              gnt0_q, gnt1_q, ack0_q, ack1_q;
    logic              gnt0_d, gnt1_d, ack0_d, ack1_d;
    logic              mem_cs_q, mem_re_q, mem_we_q;
    logic              mem_cs_d, mem_re_d, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    rr_arbiter_2 u_rr (
        .req0        (bus.req0),
        .req1        (bus.req1),
        .last_gnt    (last_gnt),
        .grant_valid (arb_valid),
        .winner      (arb_winner)
    );

    assign rd_last = (wait_cnt == WAIT_LAST);

    // State register and latched transaction.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_gnt   <= 1'b1;
            lat_client <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_data   <= '0;
            wait_cnt   <= '0;
        end else begin
            state      <= state_d;
            last_gnt   <= last_gnt_d;
            lat_client <= lat_client_d;
            lat_we     <= lat_we_d;
            lat_addr   <= lat_addr_d;
            lat_data   <= lat_data_d;
            wait_cnt   <= wait_cnt_d;
        end
    end

    // Next-state; requests are only looked at in IDLE, the winner's fields are captured on grant.
    always_comb begin
        state_d      = state;
        last_gnt_d   = last_gnt;
        lat_client_d = lat_client;
        lat_we_d     = lat_we;
        lat_addr_d   = lat_addr;
        lat_data_d   = lat_data;
        wait_cnt_d   = wait_cnt;
        case (state)
            IDLE: begin
                if (arb_valid) begin
                    state_d      = ACCESS;
                    last_gnt_d   = arb_winner;
                    lat_client_d = arb_winner;
                    lat_we_d     = arb_winner ? bus.we1    : bus.we0;
                    lat_addr_d   = arb_winner ? bus.addr1  : bus.addr0;
                    lat_data_d   = arb_winner ? bus.wdata1 : bus.wdata0;
                end
            end
            ACCESS: begin
                state_d    = lat_we ? DONE : RDWAIT;
                wait_cnt_d = '0;
            end
            RDWAIT: begin
                if (rd_last) begin
                    state_d = DONE;
                end else begin
                    wait_cnt_d = wait_cnt + WAIT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so every output leaves a flop.
    always_comb begin
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        mem_cs_d   = 1'b0;
        mem_re_d   = 1'b0;
        mem_we_d   = 1'b0;
        mem_addr_d = '0;
        mem_data_d = '0;
        rdata_d    = rdata_q;
        if (state == RDWAIT && rd_last) begin
            rdata_d = bus.mem_dataOut;
        end
        case (state_d)
            ACCESS: begin
                mem_cs_d   = 1'b1;
                mem_addr_d = lat_addr_d;
                if (lat_we_d) begin
                    mem_we_d   = 1'b1;
                    mem_data_d = lat_data_d;
                end else begin
                    mem_re_d = 1'b1;
                end
            end
            RDWAIT: begin
                mem_cs_d   = 1'b1;
                mem_re_d   = 1'b1;
                mem_addr_d = lat_addr_d;
            end
            default: begin
            end
        endcase
        if (state_d != IDLE) begin
            gnt0_d = ~lat_client_d;
            gnt1_d = lat_client_d;
        end
        if (state_d == DONE) begin
            ack0_d = ~lat_client_d;
            ack1_d = lat_client_d;
        end
    end

    // Output registers; async reset drops every strobe immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            mem_cs_q   <= 1'b0;
            mem_re_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            rdata_q    <= '0;
        end else begin
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            mem_cs_q   <= mem_cs_d;
            mem_re_q   <= mem_re_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.gnt0        = gnt0_q;
    assign bus.gnt1        = gnt1_q;
    assign bus.ack0        = ack0_q;
    assign bus.ack1        = ack1_q;
    assign bus.rdata       = rdata_q;
    assign bus.mem_cs      = mem_cs_q;
    assign bus.mem_rE      = mem_re_q;
    assign bus.mem_wE      = mem_we_q;
    assign bus.mem_address = mem_addr_q;
    assign bus.mem_data    = mem_data_q;

`ifdef MEMORY_ARBITER_STATS_EN
    // Counters step together with the ack they count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (ack0_d) begin
                grant_cnt0 <= sat_inc(grant_cnt0);
            end
            if (ack1_d) begin
                grant_cnt1 <= sat_inc(grant_cnt1);
            end
        end
    end
`endif

endmodule
